// File: rtl/uart_rx_fifo_ng.sv
// uart_rx_fifo_ng: oversampled UART receiver with majority voting feeding a FWFT receive FIFO.
// Ports: PCLK/PRESETn clock and async active-low reset; rx_tick oversample enable; RX serial line;
// rx_enable, frame_length, stop_bit, parity frame configuration; rx_data_out, rx_parity_err,
// rx_frame_err, rx_break FIFO head entry; rx_valid/rx_ready pop handshake; rx_overrun drop pulse;
// rx_fifo_level occupancy; rx_busy receiver active; rx_timeout character timeout.
// Optional feature: define RX_TIMEOUT_EN to build the character timeout, otherwise rx_timeout is 0.
module uart_rx_fifo_ng #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic rx_tick,
  input  logic RX,
  input  logic rx_enable,
  input  logic [3:0] frame_length,
  input  logic stop_bit,
  input  logic [1:0] parity,
  output logic [MAX_DATA_WIDTH-1:0] rx_data_out,
  output logic rx_parity_err,
  output logic rx_frame_err,
  output logic rx_break,
  output logic rx_valid,
  input  logic rx_ready,
  output logic rx_overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_fifo_level,
  output logic rx_busy,
  output logic rx_timeout
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int EW = MAX_DATA_WIDTH + 3;
  localparam logic [CW-1:0] S0 = CW'(OVERSAMPLE/2-1);
  localparam logic [CW-1:0] S1 = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] S2 = CW'(OVERSAMPLE/2+1);
  localparam logic [CW-1:0] SL = CW'(OVERSAMPLE-1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH, WAIT_HIGH} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic rxs, rxs_d, start, s0, s1, maj, mid;
  logic [CW-1:0] cnt;
  logic [3:0] flen_c, flen, bitcnt;
  logic sb, pen, peven, pbit, perr, ferr, brk;
  logic [MAX_DATA_WIDTH-1:0] data;
  assign rxs = sync[SYNC_STAGES-1];
  assign start = rx_enable && state == IDLE && rxs_d && !rxs;
  assign maj = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign mid = rx_tick && cnt == S2;
  assign flen_c = frame_length < 4'd5 ? 4'd5 : frame_length > 4'(MAX_DATA_WIDTH) ? 4'(MAX_DATA_WIDTH) : frame_length;
  assign rx_busy = state != IDLE;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      sync <= '1;
      rxs_d <= 1'b1;
    end else begin
      sync <= SYNC_STAGES'({sync, RX});
      rxs_d <= rxs;
    end
  // The tick counter is cleared on the start edge, so its wrap marks every later bit boundary.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state <= IDLE;
      cnt <= '0;
      s0 <= 1'b1;
      s1 <= 1'b1;
      flen <= 4'd8;
      bitcnt <= '0;
      {sb, pen, peven, pbit, perr, ferr, brk} <= '0;
      data <= '0;
    end else if (!rx_enable) begin
      state <= IDLE;
    end else if (start) begin
      state <= START;
      cnt <= '0;
      flen <= flen_c;
      {sb, pen, peven} <= {stop_bit, parity};
      bitcnt <= '0;
      {pbit, perr, ferr, brk} <= '0;
      data <= '0;
    end else begin
      if (rx_tick) begin
        cnt <= cnt == SL ? '0 : cnt + 1'b1;
        if (cnt == S0) s0 <= rxs;
        if (cnt == S1) s1 <= rxs;
      end
      case (state)
        START: if (mid) state <= maj ? IDLE : DATA;
        DATA: if (mid) begin
          data[bitcnt] <= maj;
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == flen - 1'b1) state <= pen ? PARITY : STOP1;
        end
        PARITY: if (mid) begin
          pbit <= maj;
          perr <= maj != (^data ^ ~peven);
          state <= STOP1;
        end
        STOP1: if (mid) begin
          ferr <= !maj;
          brk <= !maj && data == '0 && !(pen && pbit);
          state <= sb ? STOP2 : PUSH;
        end
        STOP2: if (mid) begin
          if (!maj) ferr <= 1'b1;
          state <= PUSH;
        end
        PUSH: state <= ferr ? WAIT_HIGH : IDLE;
        WAIT_HIGH: if (rxs) state <= IDLE;
        default: ;
      endcase
    end
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] entry, head;
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [LW-1:0] count, count_n;
  logic push, pop, full, wr;
  assign entry = {brk, ferr, perr, data};
  assign push = state == PUSH;
  assign pop = rx_valid && rx_ready;
  assign full = count == LW'(FIFO_DEPTH);
  assign wr = push && (!full || pop);
  assign rptr_n = rptr + AW'(pop);
  assign count_n = count + LW'(wr) - LW'(pop);
  assign {rx_break, rx_frame_err, rx_parity_err, rx_data_out} = head;
  assign rx_fifo_level = count;
  always_ff @(posedge PCLK)
    if (wr) mem[wptr] <= entry;
  // The head register bypasses the array when the entry being written becomes the new head.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
      head <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr_n;
      count <= count_n;
      rx_valid <= count_n != '0;
      rx_overrun <= push && full && !pop;
      head <= count_n == '0 ? '0 : (wr && wptr == rptr_n) ? entry : mem[rptr_n];
    end
`ifdef RX_TIMEOUT_EN
  logic [CW-1:0] to_tick;
  logic [7:0] to_bits, to_lim;
  assign to_lim = 8'(4 * (2 + int'(flen_c) + int'(parity[1]) + int'(stop_bit)));
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      to_tick <= '0;
      to_bits <= '0;
      rx_timeout <= 1'b0;
    end else if (pop || start || !rx_enable) begin
      to_tick <= '0;
      to_bits <= '0;
      rx_timeout <= 1'b0;
    end else if (rx_tick && count != '0 && state == IDLE && !rx_timeout) begin
      to_tick <= to_tick == SL ? '0 : to_tick + 1'b1;
      if (to_tick == SL) to_bits <= to_bits + 1'b1;
      if (to_tick == SL && to_bits + 1'b1 >= to_lim) rx_timeout <= 1'b1;
    end
`else
  assign rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo_ng.sv
// tb_uart_rx_fifo_ng: directed frames with a scoreboard queue drained by a monitor on the pop handshake.
module tb_uart_rx_fifo_ng;
  localparam int OS = 16;
  localparam int TDIV = 4;
  localparam int BIT = OS * TDIV;
  logic PCLK = 0, PRESETn = 0, rx_tick = 0, RX = 1, rx_enable = 0, stop_bit = 0, rx_ready = 0;
  logic [3:0] frame_length = 4'd8;
  logic [1:0] parity = 2'b00;
  logic [8:0] rx_data_out;
  logic rx_parity_err, rx_frame_err, rx_break, rx_valid, rx_overrun, rx_busy, rx_timeout;
  logic [3:0] rx_fifo_level;
  int vectors = 0, miscompares = 0, pops = 0, overruns = 0, pc = 0, ov = 0;
  bit busy_seen = 0, to_seen = 0;
  logic [11:0] exp_q[$];

  uart_rx_fifo_ng dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .rx_tick(rx_tick), .RX(RX), .rx_enable(rx_enable),
    .frame_length(frame_length), .stop_bit(stop_bit), .parity(parity),
    .rx_data_out(rx_data_out), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .rx_fifo_level(rx_fifo_level), .rx_busy(rx_busy), .rx_timeout(rx_timeout)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge PCLK);
      #1;
      rx_tick = (k == TDIV - 1);
      k = (k + 1) % TDIV;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (rx_busy) busy_seen = 1;
    if (rx_overrun) overruns++;
    if (rx_timeout) to_seen = 1;
    if (PRESETn && rx_valid && rx_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_entry: got 0x%0h, expected no entry", {rx_break, rx_frame_err, rx_parity_err, rx_data_out});
      end else
        check("rx_entry", {rx_break, rx_frame_err, rx_parity_err, rx_data_out}, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    RX = b;
    tick(BIT);
  endtask

  task automatic send_frame(input logic [8:0] d, input int n, input bit pen, input bit peven, input bit two, input bit flip);
    logic p;
    p = (peven ? ^d : ~^d) ^ flip;
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    if (pen) send_bit(p);
    send_bit(1'b1);
    if (two) send_bit(1'b1);
    tick(8);
  endtask

  initial begin
    tick(3);
    check("reset_outputs", {rx_data_out, rx_parity_err, rx_frame_err, rx_break, rx_valid, rx_overrun, rx_fifo_level, rx_busy, rx_timeout}, 0);
    PRESETn = 1;
    rx_enable = 1;
    tick(20);
    exp_q.push_back({3'b000, 9'h0A5});
    send_frame(9'h0A5, 8, 0, 0, 0, 0);
    check("a5_valid", rx_valid, 1);
    check("a5_level", rx_fifo_level, 1);
    check("a5_head", {rx_break, rx_frame_err, rx_parity_err, rx_data_out}, 12'h0A5);
    rx_ready = 1;
    tick(5);
    check("a5_drained", rx_fifo_level, 0);
    frame_length = 4'd9;
    parity = 2'b11;
    stop_bit = 1;
    exp_q.push_back({3'b000, 9'h1C3});
    send_frame(9'h1C3, 9, 1, 1, 1, 0);
    exp_q.push_back({3'b001, 9'h1C3});
    send_frame(9'h1C3, 9, 1, 1, 1, 1);
    frame_length = 4'd7;
    parity = 2'b10;
    stop_bit = 0;
    exp_q.push_back({3'b000, 9'h035});
    send_frame(9'h035, 7, 1, 0, 0, 0);
    frame_length = 4'd3;
    parity = 2'b00;
    exp_q.push_back({3'b000, 9'h015});
    send_frame(9'h015, 5, 0, 0, 0, 0);
    frame_length = 4'd15;
    exp_q.push_back({3'b000, 9'h12D});
    send_frame(9'h12D, 9, 0, 0, 0, 0);
    frame_length = 4'd8;
    tick(BIT);
    check("frames_popped", pops, 6);
    busy_seen = 0;
    pc = pops;
    RX = 0;
    tick(3 * TDIV);
    RX = 1;
    tick(2 * BIT);
    check("glitch_busy_pulsed", busy_seen, 1);
    check("glitch_busy_idle", rx_busy, 0);
    check("glitch_no_entry", pops - pc + rx_fifo_level, 0);
    pc = pops;
    exp_q.push_back({3'b110, 9'h000});
    RX = 0;
    tick(20 * BIT);
    check("break_wait_high_busy", rx_busy, 1);
    check("break_one_entry", pops - pc, 1);
    RX = 1;
    tick(2 * BIT);
    check("break_idle", rx_busy, 0);
    check("break_no_more", pops - pc + rx_fifo_level, 1);
    pc = pops;
    fork
      send_frame(9'h05A, 8, 0, 0, 0, 0);
      begin
        tick(4 * BIT);
        rx_enable = 0;
        tick(1);
        check("disable_idle", rx_busy, 0);
      end
    join
    tick(BIT);
    check("disable_discard", pops - pc + rx_fifo_level, 0);
    rx_enable = 1;
    tick(BIT);
    rx_ready = 0;
    ov = overruns;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({3'b000, 9'(8'h30 + i)});
      send_frame(9'(8'h30 + i), 8, 0, 0, 0, 0);
    end
    check("full_level", rx_fifo_level, 8);
    check("full_overrun_once", overruns - ov, 1);
    check("full_head", rx_data_out, 9'h030);
    exp_q.push_back({3'b000, 9'h03A});
    fork
      send_frame(9'h03A, 8, 0, 0, 0, 0);
      begin
        tick(9 * BIT + BIT / 4);
        rx_ready = 1;
        tick(1);
        rx_ready = 0;
      end
    join
    check("tenth_no_overrun", overruns - ov, 1);
    check("tenth_level", rx_fifo_level, 8);
    check("tenth_head", rx_data_out, 9'h031);
    rx_ready = 1;
    tick(20);
    check("fifo_drained", rx_fifo_level, 0);
`ifdef RX_TIMEOUT_EN
    rx_ready = 0;
    exp_q.push_back({3'b000, 9'h0A5});
    send_frame(9'h0A5, 8, 0, 0, 0, 0);
    tick(30 * BIT);
    check("timeout_early", rx_timeout, 0);
    tick(15 * BIT);
    check("timeout_set", rx_timeout, 1);
    rx_ready = 1;
    tick(3);
    check("timeout_cleared", rx_timeout, 0);
`else
    check("timeout_tied", to_seen, 0);
`endif
    tick(10);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
